// File: rtl/temp_ascii_pkg.sv
// Shared types and constants for the temperature ASCII framer and its
// BCD conversion helper.
package temp_ascii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SEND    = 2'd2
  } state_e;

  localparam int          INT_W       = 7;
  localparam int          BCD_W       = 12;
  localparam logic [10:0] MAG_SAT     = 11'h7FF;

  localparam logic [7:0]  ASCII_ZERO  = 8'h30;
  localparam logic [7:0]  ASCII_PLUS  = 8'h2B;
  localparam logic [7:0]  ASCII_MINUS = 8'h2D;
  localparam logic [7:0]  ASCII_DOT   = 8'h2E;
  localparam logic [7:0]  ASCII_CR    = 8'h0D;
  localparam logic [7:0]  ASCII_LF    = 8'h0A;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

  // Tenths of a degree from a 1/16 fraction, truncating: (frac*10)>>4.
  function automatic logic [3:0] tenths_of(input logic [3:0] frac);
    logic [7:0] prod;
    prod = {4'h0, frac} * 8'd10;
    return prod[7:4];
  endfunction

endpackage

// File: rtl/temp_ascii_framer_bin_to_bcd_seq.sv
// Iterative double-dabble: converts an INT_W-bit binary value to three BCD
// digits, one bit per clock after a load pulse; o_done stays high until reload.
module bin_to_bcd_seq
  import temp_ascii_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [INT_W-1:0] i_bin,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_done
);

  localparam int CNT_W = $clog2(INT_W + 1);

  logic [INT_W-1:0] r_shift;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [BCD_W-1:0] w_adj;

  function automatic logic [3:0] add3(input logic [3:0] n);
    if (n >= 4'd5) begin
      return n + 4'd3;
    end else begin
      return n;
    end
  endfunction

  // Per-digit +3 correction applied before each shift.
  always_comb begin
    w_adj = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
  end

  // Load, then shift one binary bit into the BCD register per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= {INT_W{1'b0}};
      r_bcd   <= {BCD_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_done  <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_bin;
      r_bcd   <= {BCD_W{1'b0}};
      r_cnt   <= CNT_W'(INT_W);
      r_done  <= 1'b0;
    end else if (r_cnt != {CNT_W{1'b0}}) begin
      r_bcd   <= {w_adj[BCD_W-2:0], r_shift[INT_W-1]};
      r_shift <= {r_shift[INT_W-2:0], 1'b0};
      r_cnt   <= r_cnt - CNT_W'(1);
      r_done  <= (r_cnt == CNT_W'(1));
    end else begin
      r_done  <= r_done;
    end
  end

  assign o_bcd  = r_bcd;
  assign o_done = r_done;

endmodule

// File: rtl/temp_ascii_framer.sv
// Formats one signed temperature sample as "sDDD.TU[CR]LF" and streams it
// byte by byte over a valid/ready handshake.
module temp_ascii_framer
  import temp_ascii_pkg::*;
#(
  parameter logic [7:0] UNIT_CHAR = 8'h43,
  parameter bit         EOL_CRLF  = 1'b1
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [15:0] i_temp_data,
  input  logic        i_sign,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_done
);

  localparam int         FRAME_LEN = EOL_CRLF ? 9 : 8;
  localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

  state_e           r_state;
  logic [3:0]       r_tenths;
  logic [7:0]       r_sign_char;
  logic [3:0]       r_idx;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_busy;
  logic             r_done;

  logic [10:0]      w_mag;
  logic             w_load;
  logic [BCD_W-1:0] w_bcd;
  logic             w_bcd_done;
  logic [3:0]       w_sel_idx;
  logic [7:0]       w_byte;

  // Magnitude saturates when any bit above the 7-bit integer field is set.
  always_comb begin
    w_mag = i_temp_data[10:0];
    if (|i_temp_data[15:11]) begin
      w_mag = MAG_SAT;
    end else begin
      w_mag = i_temp_data[10:0];
    end
  end

  assign w_load = (r_state == ST_IDLE) && i_start;

  bin_to_bcd_seq u_bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_bin  (w_mag[10:4]),
    .o_bcd  (w_bcd),
    .o_done (w_bcd_done)
  );

  // Byte mux looks one index ahead so tx_data can be registered on transfer.
  always_comb begin
    w_sel_idx = 4'd0;
    if (r_state == ST_SEND) begin
      w_sel_idx = r_idx + 4'd1;
    end else begin
      w_sel_idx = 4'd0;
    end
    case (w_sel_idx)
      4'd0:    w_byte = r_sign_char;
      4'd1:    w_byte = digit_char(w_bcd[11:8]);
      4'd2:    w_byte = digit_char(w_bcd[7:4]);
      4'd3:    w_byte = digit_char(w_bcd[3:0]);
      4'd4:    w_byte = ASCII_DOT;
      4'd5:    w_byte = digit_char(r_tenths);
      4'd6:    w_byte = UNIT_CHAR;
      4'd7:    w_byte = EOL_CRLF ? ASCII_CR : ASCII_LF;
      4'd8:    w_byte = ASCII_LF;
      default: w_byte = 8'h00;
    endcase
  end

  // Capture / convert / send sequencer with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tenths    <= 4'd0;
      r_sign_char <= ASCII_PLUS;
      r_idx       <= 4'd0;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_tenths    <= tenths_of(w_mag[3:0]);
            r_sign_char <= (i_sign && (w_mag != 11'd0)) ? ASCII_MINUS : ASCII_PLUS;
            r_idx       <= 4'd0;
            r_busy      <= 1'b1;
            r_state     <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (w_bcd_done) begin
            r_tx_data  <= w_byte;
            r_tx_valid <= 1'b1;
            r_idx      <= 4'd0;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (r_tx_valid && i_tx_ready) begin
            if (r_idx == LAST_IDX) begin
              r_tx_data  <= 8'h00;
              r_tx_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_idx      <= r_idx + 4'd1;
              r_tx_data  <= w_byte;
            end
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_temp_ascii_framer.sv
// Directed bench for temp_ascii_framer: a CR LF instance and an LF-only
// instance share the stimulus, selected by sel.
module tb_temp_ascii_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] temp_data;
  logic        sign;
  logic        tx_ready;
  logic        sel;
  logic        start0, start1;
  logic [7:0]  data0, data1, data_m;
  logic        v0, v1, b0, b1, d0, d1, v_m, b_m, d_m;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [0:8];
  int exp_n;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign data_m = sel ? data1 : data0;
  assign v_m    = sel ? v1 : v0;
  assign b_m    = sel ? b1 : b0;
  assign d_m    = sel ? d1 : d0;

  temp_ascii_framer #(.UNIT_CHAR(8'h43), .EOL_CRLF(1'b1)) dut_crlf (
    .clk(clk), .rst_n(rst_n), .i_start(start0), .i_temp_data(temp_data),
    .i_sign(sign), .o_tx_data(data0), .o_tx_valid(v0), .i_tx_ready(tx_ready),
    .o_busy(b0), .o_done(d0)
  );

  temp_ascii_framer #(.UNIT_CHAR(8'h43), .EOL_CRLF(1'b0)) dut_lf (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_temp_data(temp_data),
    .i_sign(sign), .o_tx_data(data1), .o_tx_valid(v1), .i_tx_ready(tx_ready),
    .o_busy(b1), .o_done(d1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input string s, input bit crlf);
    exp_n = 0;
    for (int i = 0; i < s.len(); i++) begin
      exp_q[exp_n] = s[i];
      exp_n++;
    end
    if (crlf) begin
      exp_q[exp_n] = 8'h0D;
      exp_n++;
    end
    exp_q[exp_n] = 8'h0A;
    exp_n++;
  endtask

  // Leaves the caller on the falling edge right after the accepting edge E0.
  task automatic pulse_start(input logic [15:0] t, input logic s);
    temp_data = t;
    sign      = s;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Collects one frame from the selected DUT; returns on the done-cycle negedge.
  task automatic run_frame(input string tag, input bit rnd, input int ign_a, input int ign_b);
    int cyc = 0;
    int idx = 0;
    int first = -1;
    int stalls = 0;
    bit stalled = 1'b0;
    logic [7:0] held = 8'h00;
    chk({tag, "_busy_e0"}, 32'(b_m), 32'd1);
    while (idx < exp_n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = (cyc == ign_a) || (cyc == ign_b);
      if (start) begin
        temp_data = 16'h07D0;
        sign      = 1'b1;
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk({tag, "_busy"}, 32'(b_m), 32'd1);
      if (stalled) begin
        chk({tag, "_stall_valid"}, 32'(v_m), 32'd1);
        chk({tag, "_stall_data"}, 32'(data_m), 32'(held));
      end
      stalled = 1'b0;
      if (v_m) begin
        if (first < 0) first = cyc;
        if (tx_ready) begin
          chk($sformatf("%s_byte%0d", tag, idx), 32'(data_m), 32'(exp_q[idx]));
          idx++;
        end else begin
          stalled = 1'b1;
          held    = data_m;
          stalls++;
        end
      end
    end
    @(negedge clk);
    cyc++;
    start    = 1'b0;
    tx_ready = 1'b1;
    chk({tag, "_latency"}, 32'(first), 32'd8);
    chk({tag, "_count"}, 32'(idx), 32'(exp_n));
    chk({tag, "_length"}, 32'(cyc), 32'(8 + exp_n + stalls));
    chk({tag, "_done"}, 32'(d_m), 32'd1);
    chk({tag, "_busy_end"}, 32'(b_m), 32'd0);
    chk({tag, "_valid_end"}, 32'(v_m), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_done_once"}, 32'(d_m), 32'd0);
    chk({tag, "_idle_busy"}, 32'(b_m), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    temp_data = 16'h0000;
    sign      = 1'b0;
    tx_ready  = 1'b1;
    sel       = 1'b0;
    #12;
    chk("rst_data0", 32'(data0), 32'h00);
    chk("rst_valid0", 32'(v0), 32'd0);
    chk("rst_busy0", 32'(b0), 32'd0);
    chk("rst_done0", 32'(d0), 32'd0);
    chk("rst_data1", 32'(data1), 32'h00);
    chk("rst_valid1", 32'(v1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    set_exp("+025.4C", 1'b1);
    pulse_start(16'h0197, 1'b0);
    run_frame("f0197", 1'b0, -1, -1);
    check_idle("f0197");

    set_exp("-010.1C", 1'b1);
    pulse_start(16'h00A2, 1'b1);
    run_frame("f00a2n", 1'b0, -1, -1);
    check_idle("f00a2n");

    set_exp("+000.0C", 1'b1);
    pulse_start(16'h0000, 1'b1);
    run_frame("fzero_neg", 1'b0, -1, -1);
    check_idle("fzero_neg");

    set_exp("+125.0C", 1'b1);
    pulse_start(16'h07D0, 1'b0);
    run_frame("f07d0", 1'b0, -1, -1);
    check_idle("f07d0");

    set_exp("+127.9C", 1'b1);
    pulse_start(16'hF000, 1'b0);
    run_frame("fsat", 1'b0, -1, -1);
    check_idle("fsat");

    // Starts in CONVERT (cycle 3) and SEND (cycle 12) must be ignored;
    // a start in the done cycle launches the next frame at once.
    set_exp("+025.4C", 1'b1);
    pulse_start(16'h0197, 1'b0);
    run_frame("fign", 1'b0, 3, 12);
    set_exp("-010.1C", 1'b1);
    pulse_start(16'h00A2, 1'b1);
    run_frame("fb2b", 1'b0, -1, -1);
    check_idle("fb2b");

    sel = 1'b1;
    set_exp("+025.4C", 1'b0);
    pulse_start(16'h0197, 1'b0);
    run_frame("lf_rnd_a", 1'b1, -1, -1);
    check_idle("lf_rnd_a");
    set_exp("-010.1C", 1'b0);
    pulse_start(16'h00A2, 1'b1);
    run_frame("lf_rnd_b", 1'b1, -1, -1);
    check_idle("lf_rnd_b");
    sel = 1'b0;

    pulse_start(16'h0197, 1'b0);
    repeat (10) @(negedge clk);
    chk("mid_send_valid", 32'(v0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(data0), 32'h00);
    chk("mid_rst_valid", 32'(v0), 32'd0);
    chk("mid_rst_busy", 32'(b0), 32'd0);
    chk("mid_rst_done", 32'(d0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(v0), 32'd0);
    set_exp("-010.1C", 1'b1);
    pulse_start(16'h00A2, 1'b1);
    run_frame("post_rst", 1'b0, -1, -1);
    check_idle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
